// File: rtl/lbist_resp_compactor.sv
// LBIST response compactor: faulty and fault-free MISRs run in lockstep per session,
// signatures are compared at session end and the fault injector is advanced with inc.
module lbist_resp_compactor #(
  parameter int unsigned       RESP_W    = 2,
  parameter int unsigned       MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
  parameter logic [MISR_W-1:0] MISR_INIT = 16'h0000,
  parameter int unsigned       PATTERNS  = 32,
  parameter int unsigned       NFAULTS   = 20,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [RESP_W-1:0] i_resp,
  input  logic [RESP_W-1:0] i_ref_resp,
  input  logic              i_fault_end,
  output logic              o_pg_load,
  output logic              o_pg_en,
  output logic              o_inc,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_detect_vld,
  output logic              o_detect,
  output logic [CNT_W-1:0]  o_det_cnt,
  output logic [CNT_W-1:0]  o_sess_cnt,
  output logic [MISR_W-1:0] o_sig_out
);

  localparam int unsigned      PAT_W    = (PATTERNS > 1) ? $clog2(PATTERNS) : 1;
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(PATTERNS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StCmp, StChk, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [PAT_W-1:0]   r_pat_cnt;
  logic [MISR_W-1:0]  r_misr_f, r_misr_r;
  logic [MISR_W-1:0]  w_misr_f_d, w_misr_r_d;
  logic               r_detect;
  logic [CNT_W-1:0]   r_det_cnt, r_sess_cnt;
  logic [MISR_W-1:0]  r_sig_out;

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                   input logic [RESP_W-1:0] r);
    misr_step = {m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? MISR_POLY : '0) ^ MISR_W'(r);
  endfunction

  assign w_misr_f_d = misr_step(r_misr_f, i_resp);
  assign w_misr_r_d = misr_step(r_misr_r, i_ref_resp);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: if (i_start) w_state_d = StLoad;
      StLoad:         w_state_d = StRun;
      StRun:          if (r_pat_cnt == PAT_LAST) w_state_d = StCmp;
      StCmp:          w_state_d = StChk;
      StChk: begin
        // sess_cnt already includes the session just compared
        if (i_fault_end || (r_sess_cnt == CNT_W'(NFAULTS))) w_state_d = StDone;
        else                                                 w_state_d = StLoad;
      end
      default:        w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat_cnt  <= '0;
      r_misr_f   <= MISR_INIT;
      r_misr_r   <= MISR_INIT;
      r_detect   <= 1'b0;
      r_det_cnt  <= '0;
      r_sess_cnt <= '0;
      r_sig_out  <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_det_cnt  <= '0;
            r_sess_cnt <= '0;
            r_sig_out  <= '0;
          end
        end
        StLoad: begin
          r_misr_f  <= MISR_INIT;
          r_misr_r  <= MISR_INIT;
          r_pat_cnt <= '0;
        end
        StRun: begin
          r_misr_f  <= w_misr_f_d;
          r_misr_r  <= w_misr_r_d;
          r_pat_cnt <= r_pat_cnt + PAT_W'(1);
          // Compare the final signatures as they are written so detect is valid in CMP
          if (r_pat_cnt == PAT_LAST) r_detect <= (w_misr_f_d != w_misr_r_d);
        end
        StCmp: begin
          r_sig_out <= r_misr_f;
          if (r_sess_cnt != '1)             r_sess_cnt <= r_sess_cnt + CNT_W'(1);
          if (r_detect && (r_det_cnt != '1)) r_det_cnt  <= r_det_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_pg_load    = (r_state == StLoad);
  assign o_pg_en      = (r_state == StRun);
  assign o_inc        = (r_state == StCmp);
  assign o_detect_vld = (r_state == StCmp);
  assign o_busy       = (r_state == StLoad) || (r_state == StRun) ||
                        (r_state == StCmp)  || (r_state == StChk);
  assign o_done       = (r_state == StDone);
  assign o_detect     = r_detect;
  assign o_det_cnt    = r_det_cnt;
  assign o_sess_cnt   = r_sess_cnt;
  assign o_sig_out    = r_sig_out;

endmodule

// File: tb/tb_lbist_resp_compactor.sv
// Bench for lbist_resp_compactor: random responses checked against a polynomial-division
// signature model, an injector model, and a vector table on a PATTERNS=1 instance.
`timescale 1ns/1ps
module tb_lbist_resp_compactor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Main instance (PATTERNS=32, NFAULTS=20)
  logic        rst_n, start, fault_end;
  logic [1:0]  resp, ref_resp;
  logic        pg_load, pg_en, inc, busy, done, detect_vld, detect;
  logic [7:0]  det_cnt, sess_cnt;
  logic [15:0] sig_out;

  lbist_resp_compactor dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_resp(resp), .i_ref_resp(ref_resp),
    .i_fault_end(fault_end), .o_pg_load(pg_load), .o_pg_en(pg_en), .o_inc(inc),
    .o_busy(busy), .o_done(done), .o_detect_vld(detect_vld), .o_detect(detect),
    .o_det_cnt(det_cnt), .o_sess_cnt(sess_cnt), .o_sig_out(sig_out)
  );

  // Second instance for single-pattern sessions
  logic        start1;
  logic [1:0]  resp1, ref1;
  logic        pg_load1, pg_en1, inc1, busy1, done1, detect_vld1, detect1;
  logic [7:0]  det_cnt1, sess_cnt1;
  logic [15:0] sig_out1;

  lbist_resp_compactor #(.PATTERNS(1), .NFAULTS(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_resp(resp1), .i_ref_resp(ref1),
    .i_fault_end(1'b0), .o_pg_load(pg_load1), .o_pg_en(pg_en1), .o_inc(inc1),
    .o_busy(busy1), .o_done(done1), .o_detect_vld(detect_vld1), .o_detect(detect1),
    .o_det_cnt(det_cnt1), .o_sess_cnt(sess_cnt1), .o_sig_out(sig_out1)
  );

  // Fault injector model: END rises once end_at INC pulses have been taken
  int   inj_cnt;
  int   end_at;
  logic inj_rst_n;
  always @(posedge clk or negedge inj_rst_n) begin
    if (!inj_rst_n) inj_cnt <= 0;
    else if (inc)   inj_cnt <= inj_cnt + 1;
  end
  assign fault_end = (inj_cnt >= end_at);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Response driver. mode 0: resp==ref; 1: one flipped bit in session 3; 2: independent
  int         mode;
  int         run_idx = 0;
  logic [1:0] drv_r;
  always @(posedge clk) begin
    #1;
    drv_r    = 2'($urandom);
    ref_resp = drv_r;
    resp     = (mode == 2) ? 2'($urandom) : drv_r;
    if (pg_en) begin
      if (mode == 1 && inj_cnt == 2 && run_idx == 7) resp[0] = ~resp[0];
      run_idx++;
    end else begin
      run_idx = 0;
    end
  end

  // Signature model: (init*x^n + sum r_i*x^(n-1-i)) mod (x^16 + 0x1021)
  logic [1:0] qf[$], qr[$];
  function automatic logic [15:0] model_sig(input bit use_ref);
    logic [63:0] b;
    int n;
    n = use_ref ? qr.size() : qf.size();
    b = 64'h0;
    for (int i = 0; i < n; i++)
      b ^= 64'(use_ref ? qr[i] : qf[i]) << (n - 1 - i);
    for (int k = 63; k >= 16; k--)
      if (b[k]) b ^= 64'h1_1021 << (k - 16);
    return b[15:0];
  endfunction

  int          exp_sess, exp_det, det_hits, last_det_sess;
  logic [15:0] exp_sig;
  bit          pend = 0;
  logic [15:0] sf, sr;
  bit          ed;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pend) begin
        check("sig_out", sig_out, exp_sig);
        check("sess_cnt", sess_cnt, exp_sess);
        check("det_cnt", det_cnt, exp_det);
        pend = 0;
      end
      check("inc_eq_vld", inc, detect_vld);
      if (pg_en) begin
        qf.push_back(resp);
        qr.push_back(ref_resp);
      end
      if (detect_vld) begin
        sf = model_sig(1'b0);
        sr = model_sig(1'b1);
        ed = (sf != sr);
        check("detect", detect, ed);
        check("pattern_count", qf.size(), 32);
        exp_sess++;
        if (ed) begin
          exp_det++;
          det_hits++;
          last_det_sess = exp_sess;
        end
        exp_sig = sf;
        qf.delete();
        qr.delete();
        pend = 1;
      end
    end
  end

  int t0;

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    qf.delete();
    qr.delete();
    exp_sess = 0; exp_det = 0; det_hits = 0; last_det_sess = 0; pend = 0;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    check("load_pg_load", pg_load, 1);
    check("load_busy", busy, 1);
    check("load_done", done, 0);
    check("load_sess_clr", sess_cnt, 0);
    check("load_det_clr", det_cnt, 0);
    check("load_sig_clr", sig_out, 0);
  endtask

  task automatic wait_done(input int bound, output int d);
    bit got;
    got = 0;
    d = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        d = cyc - t0;
        break;
      end
    end
    check("done_reached", got, 1);
  endtask

  task automatic inj_reset();
    @(negedge clk);
    inj_rst_n = 1'b0;
    #1 inj_rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  r;
    logic [1:0]  rr;
    logic [15:0] sig;
    logic        det;
  } vec_t;
  vec_t vecs[4];

  int  d;
  bit  got;

  initial begin
    vecs[0] = '{r: 2'b01, rr: 2'b00, sig: 16'h0001, det: 1'b1};
    vecs[1] = '{r: 2'b10, rr: 2'b10, sig: 16'h0002, det: 1'b0};
    vecs[2] = '{r: 2'b11, rr: 2'b01, sig: 16'h0003, det: 1'b1};
    vecs[3] = '{r: 2'b00, rr: 2'b00, sig: 16'h0000, det: 1'b0};

    rst_n = 1'b0; inj_rst_n = 1'b0; start = 1'b0; mode = 0; end_at = 20;
    start1 = 1'b0; resp1 = 2'b00; ref1 = 2'b00;
    #23;
    check("reset_outputs", {pg_load, pg_en, inc, busy, done, detect_vld, detect,
                            det_cnt, sess_cnt, sig_out}, 0);
    check("reset_outputs1", {pg_load1, pg_en1, inc1, busy1, done1, detect_vld1, detect1,
                             det_cnt1, sess_cnt1, sig_out1}, 0);
    @(negedge clk);
    rst_n = 1'b1; inj_rst_n = 1'b1;

    // Fault-free campaign: 20 sessions of 35 cycles, ended by injector END
    do_start();
    wait_done(1000, d);
    check("t1_cycles", d, 700);
    check("t1_incs", inj_cnt, 20);
    check("t1_sess", sess_cnt, 20);
    check("t1_det", det_cnt, 0);
    check("t1_busy", busy, 0);

    // Single-bit difference in session 3
    inj_reset();
    mode = 1;
    do_start();
    wait_done(1000, d);
    check("t2_det_cnt", det_cnt, 1);
    check("t2_det_hits", det_hits, 1);
    check("t2_det_sess", last_det_sess, 3);
    check("t2_sess", sess_cnt, 20);

    // END after the 5th inc, then confirm no further pulses
    inj_reset();
    mode = 2; end_at = 5;
    do_start();
    wait_done(500, d);
    check("t3_sess", sess_cnt, 5);
    check("t3_incs", inj_cnt, 5);
    repeat (50) @(negedge clk);
    check("t3_no_more_inc", inj_cnt, 5);
    check("t3_done_held", done, 1);
    check("t3_sess_held", sess_cnt, 5);

    // Session limit stops the campaign when END never arrives
    inj_reset();
    end_at = 100;
    do_start();
    wait_done(1000, d);
    check("t3b_sess", sess_cnt, 20);
    check("t3b_incs", inj_cnt, 20);

    // Async reset in the middle of session 2
    inj_reset();
    mode = 0; end_at = 20;
    do_start();
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (inj_cnt == 1 && pg_en) begin
        got = 1;
        break;
      end
    end
    check("t4_reached_s2", got, 1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_reset_outputs", {pg_load, pg_en, inc, busy, done, detect_vld, detect,
                               det_cnt, sess_cnt, sig_out}, 0);
    @(negedge clk);
    check("t4_no_inc", inj_cnt, 1);
    rst_n = 1'b1;
    inj_reset();
    end_at = 3;
    do_start();
    wait_done(500, d);
    check("t4_sess", sess_cnt, 3);

    // start during RUN is ignored; start in DONE reruns the campaign
    inj_reset();
    mode = 2; end_at = 4;
    do_start();
    repeat (5) @(negedge clk);
    check("t5_in_run", pg_en, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(500, d);
    check("t5_cycles", d, 140);
    check("t5_sess", sess_cnt, 4);
    inj_reset();
    do_start();
    wait_done(500, d);
    check("t5_rerun_cycles", d, 140);
    check("t5_rerun_sess", sess_cnt, 4);

    // Single-pattern vectors on the second instance
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      resp1 = vecs[v].r;
      ref1  = vecs[v].rr;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done1) begin
          got = 1;
          break;
        end
      end
      check("v_done", got, 1);
      check("v_sig", sig_out1, vecs[v].sig);
      check("v_detect", detect1, vecs[v].det);
      check("v_sess", sess_cnt1, 1);
      check("v_det_cnt", det_cnt1, {7'b0, vecs[v].det});
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/lbist_resp_compactor.md
Name: lbist_resp_compactor

Overview:
- Downstream response stage for the fault-injectable ISCAS85 netlists, e.g. c17 with its 20-fault one-hot injector.
- Compacts the CUT response into a MISR over one session, with one session per injected fault.
- A fault-free CUT copy, driven by the same patterns, is compacted in a second MISR in lockstep.
- At the end of each session the two signatures are compared, the detection is logged, and INC is pulsed to advance the injector. The block stops on the injector's END or after NFAULTS sessions.

Parameters:
RESP_W, 2, CUT primary-output width (c17: N22,N23)
MISR_W, 16, signature width (must be >= RESP_W)
MISR_POLY, 16'h1021, Galois feedback polynomial
MISR_INIT, 16'h0000, MISR value loaded at each session start
PATTERNS, 32, patterns applied per session (>=1)
NFAULTS, 20, session count limit
CNT_W, 8, counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  begin campaign; honoured only in IDLE/DONE
resp  in  RESP_W  faulty-CUT outputs (combinational from current pattern)
ref_resp  in  RESP_W  fault-free CUT outputs
fault_end  in  1  END from fault-injecting CUT
pg_load  out  1  pattern-generator seed reload strobe
pg_en  out  1  pattern-generator advance enable
inc  out  1  INC to fault-injecting CUT, one-cycle pulse
busy  out  1  campaign in progress
done  out  1  campaign complete, held
detect_vld  out  1  one-cycle strobe, session result valid
detect  out  1  1 = signatures differed this session
det_cnt  out  CNT_W  detected-fault count
sess_cnt  out  CNT_W  completed sessions
sig_out  out  MISR_W  last faulty signature

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs are 0. Both MISRs are set to MISR_INIT, and the pattern counter is cleared. Reset mid-session aborts with no inc pulse.
- FSM states: IDLE, LOAD, RUN, CMP, CHK, DONE.
- IDLE/DONE, start=1: go to LOAD. det_cnt, sess_cnt and sig_out clear to 0; done drops next cycle. The injector must be reset externally before a restart.
- LOAD (1 cycle):
  - pg_load=1, busy=1.
  - Both MISRs <= MISR_INIT; pattern counter <= 0.
- RUN (PATTERNS cycles):
  - pg_en=1.
  - Each cycle both MISRs update: m' = {m[MISR_W-2:0],1'b0} ^ (m[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended resp (ref_resp for the ref MISR).
  - The first sample is the seed pattern.
  - Leave RUN after the PATTERNS-th sample.
  - pg_en is 0 outside RUN.
- CMP (1 cycle):
  - detect = (faulty MISR != ref MISR), registered.
  - detect_vld=1, inc=1.
  - sig_out <= faulty MISR; sess_cnt += 1; det_cnt += detect.
  - Counters saturate at all-ones.
- CHK (1 cycle): samples fault_end, which the injector updated on the inc edge.
  - If fault_end=1 or sess_cnt==NFAULTS, go to DONE.
  - Otherwise go to LOAD.
- DONE: done=1, busy=0; hold all results.
- Session length is PATTERNS+3 cycles.
- detect holds its value until the next CMP.
- start while busy is ignored.
- fault_end is only sampled in CHK; it is ignored in other states.
- resp X during LOAD/CMP/CHK does not affect the signatures.

Test Plan:
- ref_resp tied to resp, PATTERNS=32, injector model raises fault_end on the 20th inc → 20 inc pulses, det_cnt=0, sess_cnt=20, done asserts 700 cycles after the LOAD entry cycle.
- resp differs from ref_resp in bit 0 for one RUN cycle of session 3 only → detect_vld with detect=1 in session 3 only, final det_cnt=1.
- PATTERNS=1, MISR_INIT=0, resp=2'b01, ref_resp=2'b00 → sig_out=16'h0001, detect=1.
- fault_end forced high after the 5th inc → DONE after 5 sessions, sess_cnt=5, no 6th inc.
- rst=0 pulse mid-RUN of session 2 → all outputs 0 and state IDLE immediately; a new start then gives sess_cnt counting from 1.
- start asserted during RUN → no effect; start in DONE → counters clear and the campaign reruns.
